// File: rtl/mem_fifo_pkg.sv
// Shared types, default sizes and helpers for the mem_fifo block.
package mem_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_DEPTH  = 16;

  // Status flags travel together so they are always updated from one count value.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1,
                                        almost_full: 1'b0, almost_empty: 1'b1};

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_fifo_if.sv
// Producer/consumer-side bus of mem_fifo; master drives requests, slave is the FIFO.
interface mem_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
);
  import mem_fifo_pkg::*;

  localparam int unsigned ADDR_W = clog2(DEPTH);

  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] Datain;
  logic [DATA_W-1:0] Dataout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, rd, Datain,
    input  Dataout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr, rd, Datain,
    output Dataout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/mem_fifo_ram.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
module mem_fifo_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register returns pre-write contents when both ports hit the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/mem_fifo.sv
// Synchronous FIFO control: pointers, occupancy, registered flags and error pulses.
module mem_fifo
  import mem_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned AF_THRESH = 14,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_fifo_if.slave  bus
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_next;
  fifo_flags_t       flags_q;
  fifo_flags_t       flags_next;
  logic              dout_valid_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              rd_acc_c;
  logic              wr_acc_c;
  logic [DATA_W-1:0] rd_data;

  // Accept decisions use registered flags only, so outputs never depend combinationally on inputs.
  always_comb begin
    rd_acc_c = bus.rd & ~flags_q.empty;
    wr_acc_c = bus.wr & (~flags_q.full | rd_acc_c);
  end

  // Next occupancy and the flags derived from it.
  always_comb begin
    count_next = count_q;
    case ({wr_acc_c, rd_acc_c})
      2'b10:   count_next = count_q + ONE_C;
      2'b01:   count_next = count_q - ONE_C;
      default: count_next = count_q;
    endcase
    flags_next              = FLAGS_RST;
    flags_next.full         = (count_next == DEPTH_C);
    flags_next.empty        = (count_next == '0);
    flags_next.almost_full  = (count_next >= AF_C);
    flags_next.almost_empty = (count_next <= AE_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      flags_q      <= FLAGS_RST;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc_c) rd_ptr <= rd_ptr + 1'b1;
      count_q      <= count_next;
      flags_q      <= flags_next;
      dout_valid_q <= rd_acc_c;
      overflow_q   <= bus.wr & ~wr_acc_c;
      underflow_q  <= bus.rd & ~rd_acc_c;
    end
  end

  // Reset suppresses both ports so a request coinciding with reset leaves no trace.
  mem_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc_c & ~rst),
    .wr_addr (wr_ptr),
    .wr_data (bus.Datain),
    .rd_en   (rd_acc_c & ~rst),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign bus.Dataout      = rd_data;
  assign bus.dout_valid   = dout_valid_q;
  assign bus.full         = flags_q.full;
  assign bus.empty        = flags_q.empty;
  assign bus.almost_full  = flags_q.almost_full;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_mem_fifo.sv
// Self-checking bench for mem_fifo: queue-based reference model plus directed and random traffic.
module tb_mem_fifo;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 16;
  localparam int unsigned AF  = 14;
  localparam int unsigned AE  = 2;

  logic clk;
  logic rst;

  mem_fifo_if #(.DATA_W(DW), .DEPTH(DEP)) bus ();

  mem_fifo #(
    .DATA_W    (DW),
    .DEPTH     (DEP),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: contents as a queue plus the expected registered outputs.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout  = '0;
  logic          m_valid = 1'b0;
  logic          m_ovf   = 1'b0;
  logic          m_unf   = 1'b0;
  bit            m_live  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the inputs that edge sees.
  initial begin
    bit racc, wacc;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_live  = 1'b1;
      end else if (m_live) begin
        racc = bus.rd && (mq.size() != 0);
        wacc = bus.wr && ((mq.size() != DEP) || racc);
        if (racc) m_dout = mq.pop_front();
        if (wacc) mq.push_back(bus.Datain);
        m_valid = racc;
        m_ovf   = bus.wr && !wacc;
        m_unf   = bus.rd && !racc;
      end
    end
  end

  // Every falling edge: all outputs against the model.
  initial begin
    int sz;
    forever begin
      @(negedge clk);
      if (m_live) begin
        sz = mq.size();
        chk("Dataout",      32'(bus.Dataout),      32'(m_dout));
        chk("dout_valid",   32'(bus.dout_valid),   32'(m_valid));
        chk("count",        32'(bus.count),        32'(sz));
        chk("full",         32'(bus.full),         32'(sz == DEP));
        chk("empty",        32'(bus.empty),        32'(sz == 0));
        chk("almost_full",  32'(bus.almost_full),  32'(sz >= AF));
        chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE));
        chk("overflow",     32'(bus.overflow),     32'(m_ovf));
        chk("underflow",    32'(bus.underflow),    32'(m_unf));
      end
    end
  end

  // One clock of stimulus; outputs are stable once the task returns.
  task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
    bus.wr     = w;
    bus.rd     = r;
    bus.Datain = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] fill [DEP];
    int wr_pct;
    rst        = 1'b1;
    bus.wr     = 1'b0;
    bus.rd     = 1'b0;
    bus.Datain = '0;

    // Reset held two cycles with a write pending.
    cyc(1'b1, 1'b0, 8'h99);
    cyc(1'b1, 1'b0, 8'h99);
    chk("rst_empty",   32'(bus.empty),   32'd1);
    chk("rst_count",   32'(bus.count),   32'd0);
    chk("rst_dataout", 32'(bus.Dataout), 32'h00);
    rst = 1'b0;
    cyc(1'b0, 1'b0, '0);
    chk("rst_nowrite", 32'(bus.count), 32'd0);

    // Three writes, three reads in order.
    cyc(1'b1, 1'b0, 8'hAA);
    cyc(1'b1, 1'b0, 8'h55);
    cyc(1'b1, 1'b0, 8'h0F);
    cyc(1'b0, 1'b1, '0);
    chk("rd1_data",  32'(bus.Dataout),    32'hAA);
    chk("rd1_valid", 32'(bus.dout_valid), 32'd1);
    cyc(1'b0, 1'b1, '0);
    chk("rd2_data",  32'(bus.Dataout), 32'h55);
    cyc(1'b0, 1'b1, '0);
    chk("rd3_data",  32'(bus.Dataout), 32'h0F);
    chk("rd3_empty", 32'(bus.empty),   32'd1);

    // Fill to full, overflow, then drain.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      if (i == 12) chk("af_at13", 32'(bus.almost_full), 32'd0);
      if (i == 13) chk("af_at14", 32'(bus.almost_full), 32'd1);
      if (i == 14) chk("full_at15", 32'(bus.full), 32'd0);
    end
    chk("full_at16", 32'(bus.full), 32'd1);
    cyc(1'b1, 1'b0, 8'hEE);
    chk("ovf_pulse", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count),    32'd16);
    cyc(1'b0, 1'b0, '0);
    chk("ovf_clear", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, '0);
      chk("drain_data", 32'(bus.Dataout), 32'(i));
      if (i == 12) chk("ae_at3", 32'(bus.almost_empty), 32'd0);
      if (i == 13) chk("ae_at2", 32'(bus.almost_empty), 32'd1);
    end

    // Underflow on empty; simultaneous rd&wr on empty.
    cyc(1'b0, 1'b1, '0);
    chk("unf_pulse",   32'(bus.underflow),  32'd1);
    chk("unf_valid",   32'(bus.dout_valid), 32'd0);
    chk("unf_dataout", 32'(bus.Dataout),    32'h0F);
    cyc(1'b1, 1'b1, 8'h3C);
    chk("rdwr_e_count", 32'(bus.count),     32'd1);
    chk("rdwr_e_unf",   32'(bus.underflow), 32'd1);
    cyc(1'b0, 1'b1, '0);
    chk("rdwr_e_data",  32'(bus.Dataout),   32'h3C);

    // Full with continuous rd&wr: count steady, order preserved across wrap.
    for (int i = 0; i < 16; i++) begin
      fill[i] = 8'($urandom);
      cyc(1'b1, 1'b0, fill[i]);
    end
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b1, 8'hC3);
      chk("rdwr_f_count", 32'(bus.count),    32'd16);
      chk("rdwr_f_ovf",   32'(bus.overflow), 32'd0);
      chk("rdwr_f_data",  32'(bus.Dataout),  (k < 16) ? 32'(fill[k]) : 32'hC3);
    end
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, '0);
    chk("rdwr_f_tail", 32'(bus.Dataout), 32'hC3);

    // Reset while a read is in progress.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h40 + 8'(i)));
    cyc(1'b0, 1'b1, '0);
    chk("midrd_data", 32'(bus.Dataout), 32'h40);
    rst = 1'b1;
    cyc(1'b0, 1'b1, '0);
    chk("midrst_count", 32'(bus.count),      32'd0);
    chk("midrst_empty", 32'(bus.empty),      32'd1);
    chk("midrst_valid", 32'(bus.dout_valid), 32'd0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 8'h77);
    cyc(1'b0, 1'b1, '0);
    chk("post_rst_data",  32'(bus.Dataout),    32'h77);
    chk("post_rst_valid", 32'(bus.dout_valid), 32'd1);

    // Random traffic with alternating fill/drain bias and rare resets.
    for (int n = 0; n < 3000; n++) begin
      wr_pct = ((n / 200) % 2 == 0) ? 75 : 30;
      rst = ($urandom_range(0, 399) == 0);
      cyc($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) >= wr_pct - 5,
          8'($urandom));
    end
    rst = 1'b0;
    cyc(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
